// File: rtl/bistable_ring_eval.sv
// Evaluation controller for a bistable ring PUF core.
// Each request runs N_EVAL reset/settle/sample evaluations of the ring for one
// latched challenge. It reports the majority-voted response, how many
// evaluations read as 1, and a sticky flag for sampling windows that disagreed.
module bistable_ring_eval #(
  parameter int N_STAGES   = 32,
  parameter int RESET_CYC  = 4,
  parameter int SETTLE_CYC = 64,
  parameter int SAMPLE_CYC = 4,
  parameter int N_EVAL     = 7,
  parameter int CNT_W      = $clog2(N_EVAL + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [N_STAGES-1:0] challenge,
  input  logic                ring_rsp,
  output logic                ring_reset,
  output logic [N_STAGES-1:0] ring_chal,
  output logic                busy,
  output logic                done,
  output logic                response,
  output logic                unstable,
  output logic [CNT_W-1:0]    ones_count
);

  // A single phase counter is shared by RST, SETTLE and SAMPLE, so it is
  // sized for the longest of the three phases.
  localparam int MAX_A   = (RESET_CYC > SETTLE_CYC) ? RESET_CYC : SETTLE_CYC;
  localparam int MAX_CYC = (MAX_A > SAMPLE_CYC) ? MAX_A : SAMPLE_CYC;
  localparam int CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = (N_EVAL > 1) ? $clog2(N_EVAL) : 1;
  localparam int HALF    = N_EVAL / 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q;
  logic [CYC_W-1:0]    cyc_q;
  logic [IDX_W-1:0]    idx_q;
  logic                eval_bit_q;
  logic                sync1_q;
  logic                sync2_q;
  logic                ring_reset_q;
  logic [N_STAGES-1:0] ring_chal_q;
  logic                busy_q;
  logic                done_q;
  logic                response_q;
  logic                unstable_q;
  logic [CNT_W-1:0]    ones_q;

  logic                rsp_s;
  logic                cur_bit;
  logic [CNT_W-1:0]    ones_d;
  logic                last_sample;
  logic                last_eval;

  assign rsp_s = sync2_q;

  // Two-flop synchroniser for the asynchronous ring tap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ring_rsp;
      sync2_q <= sync1_q;
    end
  end

  // Eval bit as seen this cycle (first sample cycle reads rsp_s directly, which
  // also covers a one-cycle sample window) and the ones count after adding it.
  always_comb begin
    cur_bit     = (cyc_q == '0) ? rsp_s : eval_bit_q;
    ones_d      = ones_q + CNT_W'(cur_bit);
    last_sample = (cyc_q == CYC_W'(SAMPLE_CYC - 1));
    last_eval   = (idx_q == IDX_W'(N_EVAL - 1));
  end

  // Evaluation sequencer with registered ring control and result outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      idx_q        <= '0;
      eval_bit_q   <= 1'b0;
      ring_reset_q <= 1'b1;
      ring_chal_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      response_q   <= 1'b0;
      unstable_q   <= 1'b0;
      ones_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ring_chal_q <= challenge;
            ones_q      <= '0;
            unstable_q  <= 1'b0;
            idx_q       <= '0;
            cyc_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_RST;
          end
        end
        S_RST: begin
          if (cyc_q == CYC_W'(RESET_CYC - 1)) begin
            cyc_q        <= '0;
            ring_reset_q <= 1'b0;
            state_q      <= S_SETTLE;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        S_SETTLE: begin
          if (cyc_q == CYC_W'(SETTLE_CYC - 1)) begin
            cyc_q   <= '0;
            state_q <= S_SAMPLE;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        S_SAMPLE: begin
          if (cyc_q == '0) begin
            eval_bit_q <= rsp_s;
          end else if (rsp_s != eval_bit_q) begin
            unstable_q <= 1'b1;
          end
          if (last_sample) begin
            ones_q       <= ones_d;
            cyc_q        <= '0;
            ring_reset_q <= 1'b1;
            if (last_eval) begin
              response_q <= (ones_d > CNT_W'(HALF));
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_RST;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q       <= 1'b0;
          ring_reset_q <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign ring_reset = ring_reset_q;
  assign ring_chal  = ring_chal_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign response   = response_q;
  assign unstable   = unstable_q;
  assign ones_count = ones_q;

endmodule

// File: tb/tb_bistable_ring_eval.sv
// Testbench for bistable_ring_eval with a small ring configuration.
// Period k is the clock period following edge E0+k-1, where E0 is the edge that
// accepts start. Because of the two-flop synchroniser, rsp_s in period k equals
// the ring_rsp value driven during period k-2.
module tb_bistable_ring_eval;

  localparam int NS  = 8;
  localparam int RC  = 2;
  localparam int SC  = 4;
  localparam int SMP = 4;
  localparam int NE  = 3;
  localparam int T   = RC + SC + SMP;
  localparam int CW  = $clog2(NE + 1);
  localparam int NP  = 80;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [NS-1:0] challenge = '0;
  logic          ring_rsp = 1'b0;
  logic          ring_reset;
  logic [NS-1:0] ring_chal;
  logic          busy;
  logic          done;
  logic          response;
  logic          unstable;
  logic [CW-1:0] ones_count;

  bistable_ring_eval #(
    .N_STAGES(NS), .RESET_CYC(RC), .SETTLE_CYC(SC),
    .SAMPLE_CYC(SMP), .N_EVAL(NE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .challenge(challenge),
    .ring_rsp(ring_rsp), .ring_reset(ring_reset), .ring_chal(ring_chal),
    .busy(busy), .done(done), .response(response), .unstable(unstable),
    .ones_count(ones_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit            pat     [0:NP-1];
  logic          lg_rr   [0:NP-1];
  logic          lg_busy [0:NP-1];
  logic          lg_done [0:NP-1];
  logic [NS-1:0] lg_chal [0:NP-1];
  logic [CW-1:0] lg_ones [0:NP-1];
  logic          lg_resp [0:NP-1];
  logic          lg_unst [0:NP-1];

  int            done_at;
  int            done_cnt;
  logic          r_resp;
  logic          r_unst;
  logic [CW-1:0] r_ones;

  // Reference: each evaluation's bit is the first synchronised sample of its
  // window; any later sample differing from it marks the request unstable.
  task automatic model(output logic [CW-1:0] m_ones, output logic m_unst,
                       output logic m_resp);
    int ones = 0;
    m_unst = 1'b0;
    for (int e = 0; e < NE; e++) begin
      int c0 = e * T + RC + SC + 1;
      bit b = pat[c0 - 2];
      for (int j = 1; j < SMP; j++)
        if (pat[c0 + j - 2] != b) m_unst = 1'b1;
      ones += int'(b);
    end
    m_ones = CW'(ones);
    m_resp = (ones > NE / 2);
  endtask

  // Issue one request, drive ring_rsp from pat[], log outputs for 45 periods.
  task automatic run_req(input logic [NS-1:0] chal, input int inj_k,
                         input logic [NS-1:0] inj_chal);
    done_at  = -1;
    done_cnt = 0;
    @(negedge clk);
    start     = 1'b1;
    challenge = chal;
    ring_rsp  = pat[0];
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start = (k == inj_k);
      if (k == inj_k) challenge = inj_chal;
      ring_rsp   = pat[k];
      lg_rr[k]   = ring_reset;
      lg_busy[k] = busy;
      lg_done[k] = done;
      lg_chal[k] = ring_chal;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          r_resp  = response;
          r_unst  = unstable;
          r_ones  = ones_count;
        end
      end
    end
  endtask

  task automatic fill_const(input bit v);
    for (int k = 0; k < NP; k++) pat[k] = v;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ring_reset !== 1'b1) begin errors++; $display("FAIL reset_ring_reset got %b want 1", ring_reset); end
    checks++; if (ring_chal !== '0) begin errors++; $display("FAIL reset_ring_chal got %h want 00", ring_chal); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (response !== 1'b0) begin errors++; $display("FAIL reset_response got %b want 0", response); end
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL reset_unstable got %b want 0", unstable); end
    checks++; if (ones_count !== '0) begin errors++; $display("FAIL reset_ones got %0d want 0", ones_count); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_const_one();
    int bad_rr = 0, bad_chal = 0, bad_busy = 0;
    fill_const(1'b1);
    run_req(8'hA5, 0, 8'h00);
    for (int k = 1; k <= NE * T + 1; k++) begin
      logic exp_rr = (k == NE * T + 1) ? 1'b1 : (((k - 1) % T) < RC);
      if (lg_rr[k] !== exp_rr) bad_rr++;
      if (lg_chal[k] !== 8'hA5) bad_chal++;
      if (lg_busy[k] !== 1'b1) bad_busy++;
    end
    checks++; if (done_at != 31) begin errors++; $display("FAIL const1_done_at got %0d want 31", done_at); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL const1_done_count got %0d want 1", done_cnt); end
    checks++; if (bad_rr != 0) begin errors++; $display("FAIL const1_ring_reset_pattern got %0d bad periods want 0", bad_rr); end
    checks++; if (bad_chal != 0) begin errors++; $display("FAIL const1_ring_chal got %0d bad periods want 0", bad_chal); end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL const1_busy got %0d bad periods want 0", bad_busy); end
    checks++; if (r_resp !== 1'b1) begin errors++; $display("FAIL const1_response got %b want 1", r_resp); end
    checks++; if (r_ones !== 2'd3) begin errors++; $display("FAIL const1_ones got %0d want 3", r_ones); end
    checks++; if (r_unst !== 1'b0) begin errors++; $display("FAIL const1_unstable got %b want 0", r_unst); end
    checks++; if (lg_busy[32] !== 1'b0) begin errors++; $display("FAIL const1_idle_busy got %b want 0", lg_busy[32]); end
  endtask

  task automatic test_majority();
    bit b [0:2];
    for (int p = 0; p < 2; p++) begin
      b[0] = (p == 0); b[1] = (p != 0); b[2] = (p == 0);
      fill_const(1'b0);
      for (int e = 0; e < NE; e++)
        for (int k = e * T + 1; k <= e * T + T; k++) pat[k] = b[e];
      run_req(8'h5A, 0, 8'h00);
      checks++; if (done_at != 31) begin errors++; $display("FAIL maj%0d_done_at got %0d want 31", p, done_at); end
      checks++; if (r_ones !== ((p == 0) ? 2'd2 : 2'd1)) begin errors++; $display("FAIL maj%0d_ones got %0d want %0d", p, r_ones, (p == 0) ? 2 : 1); end
      checks++; if (r_resp !== (p == 0)) begin errors++; $display("FAIL maj%0d_response got %b want %b", p, r_resp, (p == 0)); end
      checks++; if (r_unst !== 1'b0) begin errors++; $display("FAIL maj%0d_unstable got %b want 0", p, r_unst); end
    end
  endtask

  task automatic test_instability();
    // Eval 1 samples rsp_s in periods 17..20; drive 0 in period 17 so its third
    // sample (period 19) disagrees with its first.
    fill_const(1'b1);
    pat[17] = 1'b0;
    run_req(8'hC3, 0, 8'h00);
    checks++; if (r_unst !== 1'b1) begin errors++; $display("FAIL instab_unstable got %b want 1", r_unst); end
    checks++; if (r_ones !== 2'd3) begin errors++; $display("FAIL instab_ones got %0d want 3", r_ones); end
    checks++; if (r_resp !== 1'b1) begin errors++; $display("FAIL instab_response got %b want 1", r_resp); end
  endtask

  task automatic test_ignored_start();
    int bad_chal = 0;
    fill_const(1'b1);
    run_req(8'hA5, 5, 8'h3C);
    for (int k = 1; k <= 31; k++) if (lg_chal[k] !== 8'hA5) bad_chal++;
    checks++; if (bad_chal != 0) begin errors++; $display("FAIL ignstart_ring_chal got %0d bad periods want 0", bad_chal); end
    checks++; if (done_at != 31) begin errors++; $display("FAIL ignstart_done_at got %0d want 31", done_at); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ignstart_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    int second_done = -1;
    @(negedge clk);
    start = 1'b1; challenge = 8'hA5; ring_rsp = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      start     = (k == 31 || k == 32);
      challenge = 8'h5A;
      ring_rsp  = (k == 7) ? 1'b0 : (k < 32);
      lg_busy[k] = busy; lg_done[k] = done; lg_chal[k] = ring_chal;
      lg_ones[k] = ones_count; lg_resp[k] = response; lg_unst[k] = unstable;
      if (k > 32 && done === 1'b1 && second_done < 0) second_done = k;
    end
    checks++; if (lg_done[31] !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", lg_done[31]); end
    checks++; if (lg_unst[31] !== 1'b1) begin errors++; $display("FAIL b2b_first_unstable got %b want 1", lg_unst[31]); end
    checks++; if (lg_busy[32] !== 1'b0 || lg_ones[32] !== 2'd3) begin errors++; $display("FAIL b2b_idle_hold got busy %b ones %0d want busy 0 ones 3", lg_busy[32], lg_ones[32]); end
    checks++; if (lg_busy[33] !== 1'b1 || lg_chal[33] !== 8'h5A) begin errors++; $display("FAIL b2b_accept got busy %b chal %h want busy 1 chal 5a", lg_busy[33], lg_chal[33]); end
    checks++; if (lg_ones[33] !== 2'd0 || lg_unst[33] !== 1'b0) begin errors++; $display("FAIL b2b_clear got ones %0d unstable %b want 0 0", lg_ones[33], lg_unst[33]); end
    checks++; if (lg_resp[62] !== 1'b1) begin errors++; $display("FAIL b2b_response_hold got %b want 1", lg_resp[62]); end
    checks++; if (second_done != 63) begin errors++; $display("FAIL b2b_second_done_at got %0d want 63", second_done); end
    checks++; if (lg_ones[63] !== 2'd0 || lg_resp[63] !== 1'b0) begin errors++; $display("FAIL b2b_second_result got ones %0d resp %b want 0 0", lg_ones[63], lg_resp[63]); end
  endtask

  task automatic test_abort();
    int dcount = 0;
    logic a_busy, a_rr;
    logic [NS-1:0] a_chal;
    @(negedge clk);
    start = 1'b1; challenge = 8'hC3; ring_rsp = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      start   = 1'b0;
      reset_n = (k != 15);
      if (k == 16) begin a_busy = busy; a_rr = ring_reset; a_chal = ring_chal; end
      if (done === 1'b1) dcount++;
    end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", a_busy); end
    checks++; if (a_rr !== 1'b1) begin errors++; $display("FAIL abort_ring_reset got %b want 1", a_rr); end
    checks++; if (a_chal !== '0) begin errors++; $display("FAIL abort_ring_chal got %h want 00", a_chal); end
    checks++; if (dcount != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", dcount); end
    fill_const(1'b0);
    run_req(8'h3C, 0, 8'h00);
    checks++; if (done_at != 31) begin errors++; $display("FAIL abort_restart_done_at got %0d want 31", done_at); end
    checks++; if (r_ones !== 2'd0 || r_resp !== 1'b0) begin errors++; $display("FAIL abort_restart_result got ones %0d resp %b want 0 0", r_ones, r_resp); end
  endtask

  task automatic test_random();
    logic [CW-1:0] m_ones;
    logic m_unst, m_resp;
    logic [NS-1:0] chal;
    for (int it = 0; it < 20; it++) begin
      int bad_chal = 0;
      chal = NS'($urandom);
      for (int k = 0; k < NP; k++) pat[k] = bit'($urandom_range(0, 1));
      for (int e = 0; e < NE; e++) begin
        int mode = $urandom_range(0, 2);
        if (mode < 2)
          for (int k = e * T + 1; k <= e * T + T; k++) pat[k] = bit'(mode);
      end
      model(m_ones, m_unst, m_resp);
      run_req(chal, 0, 8'h00);
      for (int k = 1; k <= 31; k++) if (lg_chal[k] !== chal) bad_chal++;
      checks++; if (done_at != 31 || done_cnt != 1) begin errors++; $display("FAIL rand%0d_done got at %0d count %0d want at 31 count 1", it, done_at, done_cnt); end
      checks++; if (r_ones !== m_ones) begin errors++; $display("FAIL rand%0d_ones got %0d want %0d", it, r_ones, m_ones); end
      checks++; if (r_resp !== m_resp) begin errors++; $display("FAIL rand%0d_response got %b want %b", it, r_resp, m_resp); end
      checks++; if (r_unst !== m_unst) begin errors++; $display("FAIL rand%0d_unstable got %b want %b", it, r_unst, m_unst); end
      checks++; if (bad_chal != 0) begin errors++; $display("FAIL rand%0d_ring_chal got %0d bad periods want 0", it, bad_chal); end
    end
  endtask

  initial begin
    test_reset();
    test_const_one();
    test_majority();
    test_instability();
    test_ignored_start();
    test_back_to_back();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bistable_ring_eval.md
Name: bistable_ring_eval

Overview:
- Parametrised controller for a bistable ring PUF core of configurable stage count.
- Runs a full evaluation for one challenge: latch challenge, hold ring in reset, release, wait for settle, sample the response.
- Repeats this N_EVAL times and outputs the majority-voted response bit, a ones count and an instability flag.
- Sits between the register interface (start/challenge) and the combinational ring core (ring_reset/ring_chal/ring_rsp).

Parameters:
- N_STAGES, 32, ring stage count; width of challenge and ring_chal.
- RESET_CYC, 4, cycles ring_reset is held high per evaluation (>=1).
- SETTLE_CYC, 64, cycles after ring release before sampling (>=2, covers 2-flop synchroniser).
- SAMPLE_CYC, 4, consecutive cycles ring_rsp is sampled per evaluation (>=1).
- N_EVAL, 7, evaluations per request; odd, >=1.
- CNT_W, $clog2(N_EVAL+1), width of ones_count.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- start  in  1  request pulse; accepted only in IDLE
- challenge  in  N_STAGES  challenge, latched on accepted start
- ring_rsp  in  1  asynchronous ring output (tap)
- ring_reset  out  1  ring NOR-reset, 1 = ring forced
- ring_chal  out  N_STAGES  latched challenge to ring mux/demux selects
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse, result valid
- response  out  1  majority-voted response
- unstable  out  1  any sample mismatch in any evaluation
- ones_count  out  CNT_W  evaluations whose bit was 1

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE, ring_reset=1, ring_chal=0, busy=0, done=0, response=0, unstable=0, ones_count=0, all counters and sync flops 0. Reset mid-operation aborts immediately; no done is produced.
- ring_rsp passes through a 2-flop synchroniser -> rsp_s. Only rsp_s is used.
- FSM states: IDLE, RST, SETTLE, SAMPLE, DONE.
- IDLE: ring_reset=1. start=1 at edge E0: ring_chal<=challenge; ones_count<=0; unstable<=0; eval index<=0; next state RST. start while busy is ignored; challenge changes while busy have no effect.
- RST: ring_reset=1 for exactly RESET_CYC cycles -> SETTLE.
- SETTLE: ring_reset=0 for SETTLE_CYC cycles -> SAMPLE.
- SAMPLE: ring_reset=0 for SAMPLE_CYC cycles. The first cycle's rsp_s is the eval bit. Any later cycle in the same SAMPLE window with rsp_s != the eval bit sets unstable (sticky for the request). On the last SAMPLE cycle, ones_count += eval bit. If eval index == N_EVAL-1 -> DONE; else increment index -> RST.
- DONE: one cycle; done=1, busy=1, ring_reset=1. response = (final ones_count > N_EVAL/2); registered so it is valid in the done cycle. Next state IDLE.
- Latency: with T = RESET_CYC+SETTLE_CYC+SAMPLE_CYC, done is high in cycle E0 + N_EVAL*T + 1 (cycle after E0 = first RST cycle).
- response, unstable, ones_count hold their values after DONE until the next accepted start. ones_count/unstable clear at that start; response holds until the next DONE.
- start in the DONE cycle is ignored. start in the IDLE cycle right after DONE is accepted (back-to-back period N_EVAL*T+2).
- ones_count never exceeds N_EVAL; no wrap.

Test Plan:
(Params N_STAGES=8, RESET_CYC=2, SETTLE_CYC=4, SAMPLE_CYC=4, N_EVAL=3, T=10.)
- Reset: hold reset_n=0 3 cycles -> ring_reset=1, ring_chal=0, busy=0, done=0, response=0, unstable=0, ones_count=0.
- Constant 1: start with challenge=8'hA5, ring_rsp=1 -> ring_chal=8'hA5 from E0+1; ring_reset pattern 1,1,0x8 repeated 3 times; done exactly at E0+31; response=1, ones_count=3, unstable=0.
- Majority: ring_rsp=1 in evals 0 and 2, 0 in eval 1 (stable within each SAMPLE window) -> ones_count=2, response=1, unstable=0. Pattern 0,1,0 -> ones_count=1, response=0.
- Instability: in eval 1, rsp_s=1 on first SAMPLE cycle, 0 on third -> unstable=1 at done; eval bit 1 still counted.
- Ignored start: pulse start with challenge=8'h3C at E0+5 -> ring_chal stays 8'hA5, done still at E0+31. Start in the IDLE cycle after done is accepted, with ones_count/unstable cleared.
- Abort: reset_n=0 at E0+15 for 1 cycle -> IDLE, ring_reset=1, busy=0, no done pulse; a new start then completes normally in 31 cycles.
